// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared encodings for the RV32I multi-cycle controller.
// Holds the RV32I opcodes, the controller state enum, the immediate-format
// selector and the ALU operation / operand-select / byte-enable codes, plus
// small lookup helpers for branch operations and store byte enables.
package rv_ctrl_pkg;

    // RV32I major opcodes (INSTR[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4,
        ST_HLT = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // ALU operation codes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BLT  = 4'b1011;
    localparam logic [3:0] OP_BGE  = 4'b1100;
    localparam logic [3:0] OP_BLTU = 4'b1110;
    localparam logic [3:0] OP_BGEU = 4'b1111;

    // Operand and write-back selects
    localparam logic [1:0] A_RS1   = 2'd0;
    localparam logic [1:0] A_PC    = 2'd1;
    localparam logic [1:0] A_ZERO  = 2'd2;
    localparam logic       B_RS2   = 1'b0;
    localparam logic       B_IMM   = 1'b1;
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    // Store byte enables
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B    = 4'b0001;
    localparam logic [3:0] BE_H    = 4'b0011;
    localparam logic [3:0] BE_W    = 4'b1111;

    function automatic logic [3:0] branch_op(input logic [2:0] funct3);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = OP_BEQ;
            3'b001:  op = OP_BNE;
            3'b100:  op = OP_BLT;
            3'b101:  op = OP_BGE;
            3'b110:  op = OP_BLTU;
            3'b111:  op = OP_BGEU;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] funct3);
        logic [3:0] be;
        case (funct3)
            3'b000:  be = BE_B;
            3'b001:  be = BE_H;
            3'b010:  be = BE_W;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/rv_mc_ctrl_if.sv
// rv_mc_ctrl_if: instruction/data memory handshake bundle of the controller.
//   I_MEM_DI/I_MEM_VLD : fetched word and its valid flag (memory -> ctrl)
//   I_MEM_REQ          : fetch request (ctrl -> memory)
//   D_MEM_RDY          : data access complete (memory -> ctrl)
//   D_MEM_REQ/WEN/BE   : data request, active-low write enable, byte enables
// master = controller side, slave = memory side.
interface rv_mc_ctrl_if;
    logic [31:0] I_MEM_DI;
    logic        I_MEM_VLD;
    logic        I_MEM_REQ;
    logic        D_MEM_RDY;
    logic        D_MEM_REQ;
    logic        D_MEM_WEN;
    logic [3:0]  D_MEM_BE;

    modport master (
        input  I_MEM_DI, I_MEM_VLD, D_MEM_RDY,
        output I_MEM_REQ, D_MEM_REQ, D_MEM_WEN, D_MEM_BE
    );

    modport slave (
        output I_MEM_DI, I_MEM_VLD, D_MEM_RDY,
        input  I_MEM_REQ, D_MEM_REQ, D_MEM_WEN, D_MEM_BE
    );
endinterface

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: combinational RV32I immediate extraction.
//   instr_hi : INSTR[31:7] (the opcode is decoded by the caller)
//   imm_type : which format to extract (I/S/B/U/J, or none -> 0)
//   imm      : immediate sign-extended to XLEN
module rv_imm_gen
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr_hi,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32_s;

    // Assemble the 32-bit immediate for the selected format
    always_comb begin
        imm32_s = 32'sd0;
        case (imm_type)
            IMM_I:   imm32_s = {{20{instr_hi[31]}}, instr_hi[31:20]};
            IMM_S:   imm32_s = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
            IMM_B:   imm32_s = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7],
                                instr_hi[30:25], instr_hi[11:8], 1'b0};
            IMM_U:   imm32_s = {instr_hi[31:12], 12'h000};
            IMM_J:   imm32_s = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                                instr_hi[20], instr_hi[30:21], 1'b0};
            default: imm32_s = 32'sd0;
        endcase
    end

    // Signed cast widens with sign extension when XLEN > 32
    assign imm = XLEN'(imm32_s);

endmodule

// File: rtl/rv_mc_ctrl.sv
// rv_mc_ctrl: multi-cycle IF/ID/EX/MEM/WB controller for an RV32I datapath.
//   CLK, RST          : clock, synchronous active-high reset
//   mem (master)      : instruction/data memory handshake
//   BR_TAKEN          : branch condition from the ALU, used in EX only
//   INSTR, IMM        : instruction register and its sign-extended immediate
//   RF_RA1/RA2/WA1/WE : register file addresses and write strobe
//   OP, A_SEL, B_SEL  : ALU operation and operand selects
//   WB_SEL, PC_SEL/WE : write-back select, next-PC select and PC strobe
//   Lfunct, HALT      : load funct3, sticky halt
//   NUM_INST/NUM_CYCLE: retired-instruction and active-cycle counters
// Outputs decode from the state register and INSTR. The two exceptions are
// PC_SEL in EX (follows BR_TAKEN) and the store PC_WE in MEM (follows
// D_MEM_RDY), which must act in the same cycle to meet the cycle counts.
module rv_mc_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    rv_mc_ctrl_if.master     mem,
    input  logic             BR_TAKEN,
    output logic [31:0]      INSTR,
    output logic [XLEN-1:0]  IMM,
    output logic [4:0]       RF_RA1,
    output logic [4:0]       RF_RA2,
    output logic [4:0]       RF_WA1,
    output logic             RF_WE,
    output logic [3:0]       OP,
    output logic [1:0]       A_SEL,
    output logic             B_SEL,
    output logic [1:0]       WB_SEL,
    output logic             PC_SEL,
    output logic             PC_WE,
    output logic [2:0]       Lfunct,
    output logic             HALT,
    output logic [CNT_W-1:0] NUM_INST,
    output logic [CNT_W-1:0] NUM_CYCLE
);

    state_e           state_r, state_next_s;
    logic [31:0]      instr_r;
    logic [CNT_W-1:0] num_inst_r, num_cycle_r;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [4:0] rd_s;
    imm_type_e  imm_type_s;
    logic       known_s, is_ebreak_s, is_load_s, is_store_s, is_branch_s, is_jump_s;
    logic [3:0] op_s, be_s;
    logic [1:0] a_sel_s, wb_sel_s;
    logic       b_sel_s;
    logic [4:0] ra1_s, ra2_s, wa1_s;
    logic [2:0] lfunct_s;
    logic       i_req_s, d_req_s, d_wen_s, rf_we_s, pc_we_s, pc_sel_s, halt_s;

    assign opcode_s    = instr_r[6:0];
    assign funct3_s    = instr_r[14:12];
    assign rd_s        = instr_r[11:7];
    assign is_ebreak_s = (instr_r == INSTR_EBREAK);

    // Instruction decode: class flags, ALU controls and register addresses
    always_comb begin
        known_s     = 1'b1;
        is_load_s   = 1'b0;
        is_store_s  = 1'b0;
        is_branch_s = 1'b0;
        is_jump_s   = 1'b0;
        imm_type_s  = IMM_NONE;
        op_s        = OP_ADD;
        a_sel_s     = A_RS1;
        b_sel_s     = B_RS2;
        wb_sel_s    = WB_ALU;
        ra1_s       = 5'd0;
        ra2_s       = 5'd0;
        wa1_s       = 5'd0;
        lfunct_s    = 3'd0;
        be_s        = BE_NONE;
        case (opcode_s)
            OPC_OP: begin
                op_s  = {instr_r[30], funct3_s};
                ra1_s = instr_r[19:15];
                ra2_s = instr_r[24:20];
                wa1_s = rd_s;
            end
            OPC_OPIMM: begin
                // bit 30 only distinguishes SRAI from SRLI; elsewhere it is immediate
                op_s       = {instr_r[30] & (funct3_s == 3'b101), funct3_s};
                b_sel_s    = B_IMM;
                imm_type_s = IMM_I;
                ra1_s      = instr_r[19:15];
                wa1_s      = rd_s;
            end
            OPC_LOAD: begin
                is_load_s  = 1'b1;
                b_sel_s    = B_IMM;
                imm_type_s = IMM_I;
                wb_sel_s   = WB_LOAD;
                ra1_s      = instr_r[19:15];
                wa1_s      = rd_s;
                lfunct_s   = funct3_s;
            end
            OPC_STORE: begin
                is_store_s = 1'b1;
                b_sel_s    = B_IMM;
                imm_type_s = IMM_S;
                ra1_s      = instr_r[19:15];
                ra2_s      = instr_r[24:20];
                be_s       = store_be(funct3_s);
            end
            OPC_BRANCH: begin
                is_branch_s = 1'b1;
                imm_type_s  = IMM_B;
                op_s        = branch_op(funct3_s);
                ra1_s       = instr_r[19:15];
                ra2_s       = instr_r[24:20];
            end
            OPC_JAL: begin
                is_jump_s  = 1'b1;
                a_sel_s    = A_PC;
                b_sel_s    = B_IMM;
                imm_type_s = IMM_J;
                wb_sel_s   = WB_PC4;
                wa1_s      = rd_s;
            end
            OPC_JALR: begin
                is_jump_s  = 1'b1;
                b_sel_s    = B_IMM;
                imm_type_s = IMM_I;
                wb_sel_s   = WB_PC4;
                ra1_s      = instr_r[19:15];
                wa1_s      = rd_s;
            end
            OPC_LUI: begin
                a_sel_s    = A_ZERO;
                b_sel_s    = B_IMM;
                imm_type_s = IMM_U;
                wa1_s      = rd_s;
            end
            OPC_AUIPC: begin
                a_sel_s    = A_PC;
                b_sel_s    = B_IMM;
                imm_type_s = IMM_U;
                wa1_s      = rd_s;
            end
            // FENCE and non-EBREAK SYSTEM retire as no-ops through WB with rd=0
            OPC_FENCE:  known_s = 1'b1;
            OPC_SYSTEM: known_s = 1'b1;
            default:    known_s = 1'b0;
        endcase
    end

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_hi (instr_r[31:7]),
        .imm_type (imm_type_s),
        .imm      (IMM)
    );

    // Next-state and per-state strobes
    always_comb begin
        state_next_s = state_r;
        i_req_s      = 1'b0;
        d_req_s      = 1'b0;
        d_wen_s      = 1'b1;
        rf_we_s      = 1'b0;
        pc_we_s      = 1'b0;
        pc_sel_s     = 1'b0;
        halt_s       = 1'b0;
        case (state_r)
            ST_IF: begin
                i_req_s = 1'b1;
                if (mem.I_MEM_VLD) begin
                    state_next_s = ST_ID;
                end else begin
                    state_next_s = ST_IF;
                end
            end
            ST_ID: begin
                if (!known_s || is_ebreak_s) begin
                    state_next_s = ST_HLT;
                end else begin
                    state_next_s = ST_EX;
                end
            end
            ST_EX: begin
                if (is_branch_s) begin
                    pc_we_s      = 1'b1;
                    pc_sel_s     = BR_TAKEN;
                    state_next_s = ST_IF;
                end else if (is_load_s || is_store_s) begin
                    state_next_s = ST_MEM;
                end else begin
                    state_next_s = ST_WB;
                end
            end
            ST_MEM: begin
                d_req_s = 1'b1;
                d_wen_s = ~is_store_s;
                if (mem.D_MEM_RDY) begin
                    if (is_store_s) begin
                        pc_we_s      = 1'b1;
                        state_next_s = ST_IF;
                    end else begin
                        state_next_s = ST_WB;
                    end
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB: begin
                rf_we_s      = (rd_s != 5'd0);
                pc_we_s      = 1'b1;
                pc_sel_s     = is_jump_s;
                state_next_s = ST_IF;
            end
            ST_HLT: begin
                halt_s       = 1'b1;
                state_next_s = ST_HLT;
            end
            default: state_next_s = ST_IF;
        endcase
    end

    // State, instruction register and counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IF;
            instr_r     <= 32'd0;
            num_inst_r  <= {CNT_W{1'b0}};
            num_cycle_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_IF && mem.I_MEM_VLD) begin
                instr_r <= mem.I_MEM_DI;
            end
            if (state_r != ST_HLT) begin
                num_cycle_r <= num_cycle_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            num_inst_r <= num_inst_r + {{(CNT_W-1){1'b0}}, pc_we_s};
        end
    end

    assign mem.I_MEM_REQ = i_req_s;
    assign mem.D_MEM_REQ = d_req_s;
    assign mem.D_MEM_WEN = d_wen_s;
    assign mem.D_MEM_BE  = (state_r == ST_MEM) ? be_s : BE_NONE;

    assign INSTR     = instr_r;
    assign RF_RA1    = ra1_s;
    assign RF_RA2    = ra2_s;
    assign RF_WA1    = wa1_s;
    assign RF_WE     = rf_we_s;
    assign OP        = op_s;
    assign A_SEL     = a_sel_s;
    assign B_SEL     = b_sel_s;
    assign WB_SEL    = wb_sel_s;
    assign PC_SEL    = pc_sel_s;
    assign PC_WE     = pc_we_s;
    assign Lfunct    = lfunct_s;
    assign HALT      = halt_s;
    assign NUM_INST  = num_inst_r;
    assign NUM_CYCLE = num_cycle_r;

endmodule
